cmd_frame_parser: RTL and testbench
===================================

Name: cmd_frame_parser

Overview:
- Sits between uart_rx and the command/response state machine in the console mux.
- Assembles the raw received byte stream into complete command frames: opcode byte, then a fixed payload length per opcode.
- Validates each frame and presents opcode plus packed payload to the command executor over a valid/ready handshake.
- Replaces the single-byte, edge-triggered command latch with a clk-synchronous, framed, error-reporting front end.

Parameters:
- TIMEOUT_CYCLES, 1024, max clk cycles allowed between consecutive bytes of one frame; minimum 2.
- PAYLOAD_W, 32, width of cmd_payload; must be ≥32 (holds the 4-input × 16-output selector map).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle pulse, rx_byte valid (uart_rx ready, resynchronised to clk upstream)
- rx_byte  in  8  received byte
- cmd_valid  out  1  decoded command available
- cmd_ready  in  1  executor accepts command
- cmd_op  out  3  opcode (COMM_* encoding)
- cmd_payload  out  PAYLOAD_W  payload, MSB-first bytes right-justified
- err_unknown  out  1  one-cycle pulse: invalid opcode byte
- err_timeout  out  1  one-cycle pulse: inter-byte timeout, frame dropped
- err_overrun  out  1  one-cycle pulse: byte arrived while command pending, byte dropped
- err_checksum  out  1  one-cycle pulse: checksum mismatch (tied 0 without feature)

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE; all outputs 0; payload and counters cleared.
  - Reset mid-frame or mid-handshake discards everything.
- Opcodes (byte[7:3] must be 0) and payload lengths:
  - READ_ENABLE_MASK=1: 0 bytes.
  - READ_PIN_MAP=2: 0 bytes.
  - WRITE_ENABLE_MASK=3: 2 bytes.
  - WRITE_PIN_MAP=4: 4 bytes.
- Any other byte value (including 0, 5–7, or upper bits set):
  - err_unknown pulses the next cycle; state stays IDLE.
- States: IDLE, PAYLOAD, [CHECK], ISSUE.
- IDLE + rx_valid with valid opcode:
  - Latch op, clear payload, load byte count.
  - If count=0: go to ISSUE (or CHECK when the optional feature is enabled).
  - Else: go to PAYLOAD.
- PAYLOAD + rx_valid:
  - payload <= {payload[PAYLOAD_W-9:0], rx_byte}; decrement count.
  - On last byte: go to ISSUE/CHECK.
- ISSUE:
  - cmd_valid=1 with cmd_op/cmd_payload stable until cmd_valid&&cmd_ready.
  - The cycle after the handshake: cmd_valid=0, state=IDLE.
  - Latency: cmd_valid rises one cycle after the rx_valid of the frame's final byte.
- Unused payload bits are zero:
  - WRITE_ENABLE_MASK → payload[15:0]={b1,b2}.
  - WRITE_PIN_MAP → {b1,b2,b3,b4}.
- Timeout:
  - Counter runs only in PAYLOAD/CHECK and resets on every accepted byte.
  - Reaching TIMEOUT_CYCLES-1 pulses err_timeout, drops the frame, returns to IDLE.
  - rx_valid on the expiry cycle wins: byte accepted, no error.
- rx_valid while in ISSUE:
  - Byte dropped; err_overrun pulses the next cycle.
  - This applies even if cmd_ready handshakes that same cycle.
  - The pending command is unaffected.
- Error pulses are mutually exclusive per cycle and never coincide with a cmd_valid rising edge of the same frame.

Optional Feature:
- Macro: CMD_FRAME_PARSER_CHECKSUM_EN.
- Defined:
  - Every frame carries one trailing byte = XOR of the opcode byte and all payload bytes.
  - State CHECK awaits it, under the same timeout rules.
  - Match → ISSUE. Mismatch → err_checksum pulse, frame dropped, IDLE.
- Undefined:
  - No CHECK state; err_checksum constant 0; frames as above.

Decomposition:
- Shared package comm_pkg:
  - COMM_* opcode localparams (3-bit).
  - Per-opcode payload length function/constants.
  - Parser state enum encoding.
- Same package reused by the executor and the TX response path.
- Sub-module: interbyte_timer (load/clear, enable, expiry pulse, width $clog2(TIMEOUT_CYCLES)).

Test Plan:
- Send 0x01, cmd_ready=1 → cmd_valid one cycle after rx_valid, cmd_op=1, cmd_payload=0, deasserts next cycle.
- Send 0x03,0xAA,0x55 → cmd_op=3, cmd_payload=0x0000AA55. Send 0x04,0x12,0x34,0x56,0x78 with cmd_ready held 0 for 20 cycles → cmd_payload=0x12345678 held stable throughout.
- Send 0x07, then 0x81 → two err_unknown pulses, no cmd_valid; subsequent 0x02 decodes normally.
- Send 0x03,0xAA then idle TIMEOUT_CYCLES → err_timeout pulse, no cmd_valid. Repeat with second byte arriving exactly on the expiry cycle → accepted.
- While cmd_valid pending, inject 0x01 → err_overrun, original command delivered unchanged. Also assert rst_n=0 mid-payload → outputs 0, next frame decodes cleanly.
- With CMD_FRAME_PARSER_CHECKSUM_EN: 0x03,0xAA,0x55,0xFC → accepted. 0x03,0xAA,0x55,0x00 → err_checksum, no cmd_valid.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared console command encoding, payload lengths and parser state encoding.
// CMD_FRAME_PARSER_CHECKSUM_EN adds the PS_CHECK state for the trailing XOR byte.
package comm_pkg;

    localparam logic [2:0] COMM_READ_ENABLE_MASK  = 3'd1;
    localparam logic [2:0] COMM_READ_PIN_MAP      = 3'd2;
    localparam logic [2:0] COMM_WRITE_ENABLE_MASK = 3'd3;
    localparam logic [2:0] COMM_WRITE_PIN_MAP     = 3'd4;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_PAYLOAD = 2'd1,
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
        PS_CHECK   = 2'd2,
`endif
        PS_ISSUE   = 2'd3
    } parse_state_e;

    function automatic logic [2:0] comm_len(input logic [2:0] op);
        case (op)
            COMM_WRITE_ENABLE_MASK: comm_len = 3'd2;
            COMM_WRITE_PIN_MAP:     comm_len = 3'd4;
            default:                comm_len = 3'd0;
        endcase
    endfunction

    function automatic logic comm_op_ok(input logic [7:0] b);
        comm_op_ok = (b[7:3] == 5'd0) &&
                     (b[2:0] >= COMM_READ_ENABLE_MASK) &&
                     (b[2:0] <= COMM_WRITE_PIN_MAP);
    endfunction

endpackage

// File: rtl/interbyte_timer.sv
// Counts idle cycles between bytes of one frame; flags the last allowed cycle.
// Cleared on every received byte, counts only while enabled.
module interbyte_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// Frames the uart_rx byte stream into opcode + payload commands for the executor.
// CMD_FRAME_PARSER_CHECKSUM_EN enables the trailing XOR checksum byte.
module cmd_frame_parser
    import comm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PAYLOAD_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [2:0]           cmd_op,
    output logic [PAYLOAD_W-1:0] cmd_payload,
    output logic                 err_unknown,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic                 err_checksum
);

`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
    localparam parse_state_e DONE_ST = PS_CHECK;
`else
    localparam parse_state_e DONE_ST = PS_ISSUE;
`endif

    parse_state_e         r_state, w_state_nxt;
    logic [2:0]           r_op, w_op_nxt;
    logic [PAYLOAD_W-1:0] r_payload, w_payload_nxt;
    logic [2:0]           r_cnt, w_cnt_nxt;
    logic                 r_unk, w_unk_nxt;
    logic                 r_tmo, w_tmo_nxt;
    logic                 r_ovr, w_ovr_nxt;
    logic                 w_tmr_en;
    logic                 w_expired;
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
    logic [7:0]           r_csum, w_csum_nxt;
    logic                 r_chk, w_chk_nxt;
`endif

`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
    assign w_tmr_en = (r_state == PS_PAYLOAD) || (r_state == PS_CHECK);
`else
    assign w_tmr_en = (r_state == PS_PAYLOAD);
`endif

    interbyte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (rx_valid),
        .i_en     (w_tmr_en),
        .o_expired(w_expired)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_payload_nxt = r_payload;
        w_cnt_nxt     = r_cnt;
        w_unk_nxt     = 1'b0;
        w_tmo_nxt     = 1'b0;
        w_ovr_nxt     = 1'b0;
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
        w_csum_nxt    = r_csum;
        w_chk_nxt     = 1'b0;
`endif
        unique case (r_state)
            PS_IDLE: begin
                if (rx_valid && comm_op_ok(rx_byte)) begin
                    w_op_nxt      = rx_byte[2:0];
                    w_payload_nxt = '0;
                    w_cnt_nxt     = comm_len(rx_byte[2:0]);
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
                    w_csum_nxt    = rx_byte;
`endif
                    w_state_nxt   = (w_cnt_nxt == 3'd0) ? DONE_ST : PS_PAYLOAD;
                end else if (rx_valid) begin
                    w_unk_nxt = 1'b1;
                end
            end
            PS_PAYLOAD: begin
                // a byte on the expiry cycle still counts as on time
                if (rx_valid) begin
                    w_payload_nxt = {r_payload[PAYLOAD_W-9:0], rx_byte};
                    w_cnt_nxt     = r_cnt - 3'd1;
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
                    w_csum_nxt    = r_csum ^ rx_byte;
`endif
                    if (r_cnt == 3'd1) w_state_nxt = DONE_ST;
                end else if (w_expired) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = PS_IDLE;
                end
            end
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
            PS_CHECK: begin
                if (rx_valid) begin
                    w_chk_nxt   = (rx_byte != r_csum);
                    w_state_nxt = (rx_byte == r_csum) ? PS_ISSUE : PS_IDLE;
                end else if (w_expired) begin
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = PS_IDLE;
                end
            end
`endif
            PS_ISSUE: begin
                w_ovr_nxt = rx_valid;
                if (cmd_ready) w_state_nxt = PS_IDLE;
            end
            default: w_state_nxt = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= PS_IDLE;
            r_op      <= '0;
            r_payload <= '0;
            r_cnt     <= '0;
            r_unk     <= 1'b0;
            r_tmo     <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
            r_csum    <= '0;
            r_chk     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_payload <= w_payload_nxt;
            r_cnt     <= w_cnt_nxt;
            r_unk     <= w_unk_nxt;
            r_tmo     <= w_tmo_nxt;
            r_ovr     <= w_ovr_nxt;
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
            r_csum    <= w_csum_nxt;
            r_chk     <= w_chk_nxt;
`endif
        end
    end

    assign cmd_valid   = (r_state == PS_ISSUE);
    assign cmd_op      = r_op;
    assign cmd_payload = r_payload;
    assign err_unknown = r_unk;
    assign err_timeout = r_tmo;
    assign err_overrun = r_ovr;
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
    assign err_checksum = r_chk;
`else
    assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser; inputs driven and outputs sampled on negedge.
module tb_cmd_frame_parser;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_payload;
    logic        err_unknown;
    logic        err_timeout;
    logic        err_overrun;
    logic        err_checksum;

    int n_cmp = 0;
    int n_bad = 0;

    cmd_frame_parser #(
        .TIMEOUT_CYCLES(TMO),
        .PAYLOAD_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_payload (cmd_payload),
        .err_unknown (err_unknown),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_checksum(err_checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send(input logic [7:0] op, input int n, input logic [31:0] pl);
        logic [7:0] cs;
        cs = op;
        pulse(op);
        for (int i = n - 1; i >= 0; i--) begin
            pulse(pl[8*i +: 8]);
            cs ^= pl[8*i +: 8];
        end
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
        pulse(cs);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_op", cmd_op, 0);
        check("rst_payload", cmd_payload, 0);
        check("rst_errs", {err_unknown, err_timeout, err_overrun, err_checksum}, 0);
        rst_n = 1'b1;
        tick();

        // zero-length opcode
        cmd_ready = 1'b1;
        check("pre_valid", cmd_valid, 0);
        send(8'h01, 0, 32'h0);
        check("rd_mask_valid", cmd_valid, 1);
        check("rd_mask_op", cmd_op, 1);
        check("rd_mask_payload", cmd_payload, 0);
        tick();
        check("rd_mask_drop", cmd_valid, 0);

        send(8'h03, 2, 32'h0000AA55);
        check("wr_mask_valid", cmd_valid, 1);
        check("wr_mask_op", cmd_op, 3);
        check("wr_mask_payload", cmd_payload, 32'h0000AA55);
        tick();
        check("wr_mask_drop", cmd_valid, 0);

        // back-pressure and overrun while pending
        cmd_ready = 1'b0;
        send(8'h04, 4, 32'h12345678);
        for (int i = 0; i < 20; i++) begin
            check("pin_hold_valid", cmd_valid, 1);
            check("pin_hold_payload", cmd_payload, 32'h12345678);
            if (i == 5) begin
                pulse(8'h01);
                check("ovr_pulse", err_overrun, 1);
                check("ovr_op", cmd_op, 4);
            end else begin
                tick();
            end
            if (i == 6) check("ovr_clear", err_overrun, 0);
        end
        // overrun in the same cycle as the handshake
        cmd_ready = 1'b1;
        pulse(8'h01);
        check("ovr_hs_pulse", err_overrun, 1);
        check("ovr_hs_valid", cmd_valid, 0);
        tick();
        check("ovr_hs_clear", err_overrun, 0);
        check("ovr_hs_dropped", cmd_valid, 0);

        // unknown opcodes
        pulse(8'h07);
        check("unk7_pulse", err_unknown, 1);
        check("unk7_valid", cmd_valid, 0);
        tick();
        check("unk7_clear", err_unknown, 0);
        pulse(8'h81);
        check("unk81_pulse", err_unknown, 1);
        tick();
        check("unk81_clear", err_unknown, 0);
        send(8'h02, 0, 32'h0);
        check("rd_pin_valid", cmd_valid, 1);
        check("rd_pin_op", cmd_op, 2);
        tick();

        // timeout expires
        pulse(8'h03);
        pulse(8'hAA);
        repeat (TMO - 1) tick();
        check("tmo_early", err_timeout, 0);
        tick();
        check("tmo_pulse", err_timeout, 1);
        check("tmo_valid", cmd_valid, 0);
        tick();
        check("tmo_clear", err_timeout, 0);
        send(8'h01, 0, 32'h0);
        check("tmo_recover", cmd_valid, 1);
        tick();

        // byte exactly on the expiry cycle is accepted
        pulse(8'h03);
        pulse(8'hAA);
        repeat (TMO - 1) tick();
        pulse(8'h55);
        check("tmo_edge_err", err_timeout, 0);
`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
        pulse(8'hFC);
`endif
        check("tmo_edge_valid", cmd_valid, 1);
        check("tmo_edge_payload", cmd_payload, 32'h0000AA55);
        tick();

        // reset mid-frame
        pulse(8'h04);
        pulse(8'h12);
        pulse(8'h34);
        rst_n = 1'b0;
        tick();
        check("midrst_valid", cmd_valid, 0);
        check("midrst_op", cmd_op, 0);
        check("midrst_payload", cmd_payload, 0);
        rst_n = 1'b1;
        tick();
        send(8'h03, 2, 32'h00001234);
        check("postrst_valid", cmd_valid, 1);
        check("postrst_payload", cmd_payload, 32'h00001234);
        tick();
        check("no_csum_err", err_checksum, 0);

`ifdef CMD_FRAME_PARSER_CHECKSUM_EN
        pulse(8'h03);
        pulse(8'hAA);
        pulse(8'h55);
        pulse(8'hFC);
        check("csum_ok_valid", cmd_valid, 1);
        check("csum_ok_err", err_checksum, 0);
        tick();
        pulse(8'h03);
        pulse(8'hAA);
        pulse(8'h55);
        pulse(8'h00);
        check("csum_bad_err", err_checksum, 1);
        check("csum_bad_valid", cmd_valid, 0);
        tick();
        check("csum_bad_clear", err_checksum, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
